// File: rtl/axi_mem_read_responder.sv
// AXI4 read-channel responder: serves AR/R bursts from a synchronous memory read port
// through a 2-entry output buffer that absorbs memory latency and RREADY backpressure.
module axi_mem_read_responder #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 10
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ID_WIDTH-1:0]   ARID,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [ID_WIDTH-1:0]   RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  MEM_REN,
  output logic [DEPTH-1:0]      MEM_RADDR,
  input  logic [DATA_WIDTH-1:0] MEM_DOUT
);

  localparam int B = $clog2(DATA_WIDTH / 8);
  localparam logic [2:0] SIZE_B = 3'(B);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                r_state, w_state_next;
  logic                  r_arready, w_arready_next;
  logic [ID_WIDTH-1:0]   r_id;
  logic [DEPTH-1:0]      r_addr, w_addr_next, w_mask;
  logic [7:0]            r_len;
  logic [1:0]            r_burst;
  logic                  r_err;
  logic [8:0]            r_left;
  logic                  r_inflight, r_inflight_last;
  logic [1:0]            r_count;
  logic                  r_head, r_tail;
  logic [DATA_WIDTH-1:0] r_buf_data [2];
  logic [1:0]            r_buf_resp [2];
  logic                  r_buf_last [2];

  logic                  w_ar_hs, w_ar_err, w_wrap_len_ok;
  logic                  w_pop, w_push, w_issue;
  logic [2:0]            w_occ;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic [1:0]            w_push_resp;
  logic                  w_unused;

  assign w_ar_hs       = r_arready & ARVALID;
  assign w_wrap_len_ok = (ARLEN == 8'd1) | (ARLEN == 8'd3) | (ARLEN == 8'd7) | (ARLEN == 8'd15);
  assign w_ar_err      = (ARSIZE != SIZE_B) | (ARBURST == 2'b11) |
                         ((ARBURST == 2'b10) & ~w_wrap_len_ok);

  // Slots committed = buffered beats plus the read whose data lands next edge.
  assign w_pop   = (r_count != 2'd0) & RREADY;
  assign w_push  = r_inflight;
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_state == S_BURST) & (r_left != 9'd0) & (w_occ < 3'd2);

  assign w_mask = DEPTH'(r_len);
  always_comb begin
    w_addr_next = r_addr;
    case (r_burst)
      2'b00:   w_addr_next = r_addr;
      2'b10:   w_addr_next = (r_addr & ~w_mask) | ((r_addr + DEPTH'(1)) & w_mask);
      default: w_addr_next = r_addr + DEPTH'(1);
    endcase
  end

  always_comb begin
    w_state_next   = r_state;
    w_arready_next = r_arready;
    case (r_state)
      S_IDLE: begin
        w_arready_next = 1'b1;
        if (w_ar_hs) begin
          w_state_next   = S_BURST;
          w_arready_next = 1'b0;
        end
      end
      S_BURST: begin
        w_arready_next = 1'b0;
        if (w_pop && r_buf_last[r_head]) begin
          w_state_next   = S_IDLE;
          w_arready_next = 1'b1;
        end
      end
      default: begin
        w_state_next   = S_IDLE;
        w_arready_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= S_IDLE;
      r_arready <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_arready <= w_arready_next;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_id            <= '0;
      r_addr          <= '0;
      r_len           <= '0;
      r_burst         <= '0;
      r_err           <= 1'b0;
      r_left          <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_id    <= ARID;
        r_addr  <= ARADDR[DEPTH+B-1:B];
        r_len   <= ARLEN;
        r_burst <= ARBURST;
        r_err   <= w_ar_err;
        r_left  <= {1'b0, ARLEN} + 9'd1;
      end else if (w_issue) begin
        r_left <= r_left - 9'd1;
        r_addr <= w_addr_next;
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & (r_left == 9'd1);
    end
  end

  // Error bursts flow through the same slot accounting, just with no memory access.
  assign w_push_data = r_err ? '0 : MEM_DOUT;
  assign w_push_resp = r_err ? 2'b10 : 2'b00;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
          r_buf_data[gi] <= '0;
          r_buf_resp[gi] <= '0;
          r_buf_last[gi] <= 1'b0;
        end else if (w_push && (r_tail == 1'(gi))) begin
          r_buf_data[gi] <= w_push_data;
          r_buf_resp[gi] <= w_push_resp;
          r_buf_last[gi] <= r_inflight_last;
        end
      end
    end
  endgenerate

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_count <= '0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
    end else begin
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      if (w_push) r_tail <= ~r_tail;
      if (w_pop)  r_head <= ~r_head;
    end
  end

  assign ARREADY   = r_arready;
  assign RID       = r_id;
  assign RDATA     = r_buf_data[r_head];
  assign RRESP     = r_buf_resp[r_head];
  assign RLAST     = r_buf_last[r_head];
  assign RVALID    = (r_count != 2'd0);
  assign MEM_REN   = w_issue & ~r_err;
  assign MEM_RADDR = r_addr;

  // Upper address bits alias by design; wide ARLEN bits only matter for WRAP masks.
  assign w_unused = ^{ARADDR, r_len};

endmodule

// File: tb/tb_axi_mem_read_responder.sv
// Bench for axi_mem_read_responder: table of bursts with explicit expected words, a beat
// scoreboard, stall-stability and outstanding-read checks, plus a mid-burst reset sequence.
module tb_axi_mem_read_responder;

  localparam int IDW = 4;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int DEP = 4;

  logic           ACLK = 1'b0;
  logic           ARESETn = 1'b0;
  logic [IDW-1:0] ARID = '0;
  logic [AW-1:0]  ARADDR = '0;
  logic [7:0]     ARLEN = '0;
  logic [2:0]     ARSIZE = '0;
  logic [1:0]     ARBURST = '0;
  logic           ARVALID = 1'b0;
  logic           ARREADY;
  logic [IDW-1:0] RID;
  logic [DW-1:0]  RDATA;
  logic [1:0]     RRESP;
  logic           RLAST;
  logic           RVALID;
  logic           RREADY = 1'b0;
  logic           MEM_REN;
  logic [DEP-1:0] MEM_RADDR;
  logic [DW-1:0]  MEM_DOUT = '0;

  axi_mem_read_responder #(
    .ID_WIDTH(IDW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY),
    .MEM_REN(MEM_REN), .MEM_RADDR(MEM_RADDR), .MEM_DOUT(MEM_DOUT)
  );

  always #5 ACLK = ~ACLK;

  logic [DW-1:0] mem [0:(1<<DEP)-1];
  always @(posedge ACLK) if (MEM_REN) MEM_DOUT <= mem[MEM_RADDR];

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic [1:0]     resp;
    logic           last;
  } beat_t;

  typedef struct packed {
    logic [IDW-1:0]       id;
    logic [AW-1:0]        addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 rnd;
    logic                 err;
    logic [3:0][DEP-1:0]  w;
  } ent_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    issued, popped, cyc_n, first_v;
  bit    err_mode = 1'b0;
  bit    hold_v = 1'b0;
  beat_t hold_b;

  function automatic logic [DW-1:0] memval(input logic [DEP-1:0] i);
    return {20'hD0000, i, i, i};
  endfunction

  function automatic beat_t cur();
    beat_t b;
    b.id = RID; b.data = RDATA; b.resp = RRESP; b.last = RLAST;
    return b;
  endfunction

  function automatic ent_t mk(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                              input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic rnd, input logic err,
                              input logic [DEP-1:0] w0, input logic [DEP-1:0] w1,
                              input logic [DEP-1:0] w2, input logic [DEP-1:0] w3);
    ent_t e;
    e.id = id; e.addr = addr; e.len = len; e.size = size; e.burst = burst;
    e.rnd = rnd; e.err = err; e.w = {w3, w2, w1, w0};
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // One bus cycle, entered at a falling edge; samples after RREADY settles.
  task automatic cyc(input bit rr);
    beat_t e;
    RREADY = rr;
    #1;
    if (hold_v) chk("stall_hold", 64'({RVALID, cur()}), 64'({1'b1, hold_b}));
    hold_v = RVALID && !RREADY;
    hold_b = cur();
    if (RVALID && first_v < 0) first_v = cyc_n;
    if (err_mode) chk("err_no_ren", 64'(MEM_REN), 64'(0));
    if (RVALID && RREADY) begin
      chk("beat_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat", 64'(cur()), 64'(e));
      end
      popped++;
    end
    if (MEM_REN) issued++;
    chk("outstanding_le2", 64'((issued - popped) > 2), 64'(0));
    @(posedge ACLK);
    @(negedge ACLK);
    cyc_n++;
  endtask

  task automatic start_ar(input ent_t t);
    ARID = t.id; ARADDR = t.addr; ARLEN = t.len; ARSIZE = t.size; ARBURST = t.burst;
    ARVALID = 1'b1;
    #1;
    for (int k = 0; k < 20 && !ARREADY; k++) begin
      @(posedge ACLK);
      @(negedge ACLK);
      #1;
    end
    chk("ar_ready", 64'(ARREADY), 64'(1));
    @(posedge ACLK);
    @(negedge ACLK);
    ARVALID = 1'b0;
    issued = 0; popped = 0; cyc_n = 0; first_v = -1;
    err_mode = t.err;
    RREADY = 1'b0;
    #1;
    chk("arready_low_in_burst", 64'(ARREADY), 64'(0));
    chk("ren_after_ar", 64'(MEM_REN), 64'(!t.err));
  endtask

  task automatic run(input ent_t t);
    beat_t b;
    $display("burst id=%0d addr=%h len=%0d size=%0d burst=%0d rnd=%0d err=%0d",
             t.id, t.addr, t.len, t.size, t.burst, t.rnd, t.err);
    for (int i = 0; i <= int'(t.len); i++) begin
      b.id   = t.id;
      b.data = t.err ? '0 : memval(t.w[i]);
      b.resp = t.err ? 2'b10 : 2'b00;
      b.last = (i == int'(t.len));
      exp_q.push_back(b);
    end
    start_ar(t);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++)
      cyc(t.rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    #1;
    chk("arready_back", 64'(ARREADY), 64'(1));
    chk("latency", 64'(first_v), 64'(2));
    if (!t.err) chk("reads_issued", 64'(issued), 64'(int'(t.len) + 1));
    cyc(1'b1);
    cyc(1'b1);
    err_mode = 1'b0;
  endtask

  ent_t tbl [10];
  ent_t rst_ent;
  beat_t rb;

  initial begin
    for (int i = 0; i < (1 << DEP); i++) mem[i] = memval(DEP'(i));

    tbl[0] = mk(4'd3, 32'h10,        8'd3, 3'd2, 2'b01, 1'b0, 1'b0, 4, 5, 6, 7);
    tbl[1] = mk(4'd5, 32'h10,        8'd3, 3'd2, 2'b01, 1'b1, 1'b0, 4, 5, 6, 7);
    tbl[2] = mk(4'd1, 32'h18,        8'd3, 3'd2, 2'b10, 1'b0, 1'b0, 6, 7, 4, 5);
    tbl[3] = mk(4'd2, 32'h08,        8'd2, 3'd2, 2'b00, 1'b1, 1'b0, 2, 2, 2, 0);
    tbl[4] = mk(4'd7, 32'h38,        8'd3, 3'd2, 2'b01, 1'b0, 1'b0, 14, 15, 0, 1);
    tbl[5] = mk(4'd9, 32'h10,        8'd1, 3'd1, 2'b01, 1'b0, 1'b1, 0, 0, 0, 0);
    tbl[6] = mk(4'd4, 32'h10,        8'd1, 3'd2, 2'b11, 1'b1, 1'b1, 0, 0, 0, 0);
    tbl[7] = mk(4'd8, 32'h10,        8'd2, 3'd2, 2'b10, 1'b0, 1'b1, 0, 0, 0, 0);
    tbl[8] = mk(4'd6, 32'h3C,        8'd1, 3'd2, 2'b10, 1'b1, 1'b0, 15, 14, 0, 0);
    tbl[9] = mk(4'hC, 32'h1000_0010, 8'd1, 3'd2, 2'b01, 1'b1, 1'b0, 4, 5, 0, 0);

    repeat (3) @(negedge ACLK);
    #1;
    chk("reset_outputs", 64'({ARREADY, RVALID, RLAST, MEM_REN, RRESP, RID, RDATA, MEM_RADDR}),
        64'(0));
    ARESETn = 1'b1;
    #1;
    chk("arready_before_edge", 64'(ARREADY), 64'(0));
    @(posedge ACLK);
    @(negedge ACLK);
    #1;
    chk("arready_after_edge", 64'(ARREADY), 64'(1));
    @(negedge ACLK);

    for (int i = 0; i < 10; i++) run(tbl[i]);

    // Reset in the middle of an 8-beat burst, after two beats have been taken.
    rst_ent = mk(4'hA, 32'h0, 8'd7, 3'd2, 2'b01, 1'b0, 1'b0, 0, 0, 0, 0);
    $display("burst id=%0d addr=%h len=%0d (reset after beat 2)", rst_ent.id, rst_ent.addr,
             rst_ent.len);
    for (int i = 0; i < 8; i++) begin
      rb.id = 4'hA; rb.data = memval(DEP'(i)); rb.resp = 2'b00; rb.last = (i == 7);
      exp_q.push_back(rb);
    end
    start_ar(rst_ent);
    for (int k = 0; k < 50 && popped < 2; k++) cyc(1'b1);
    chk("pre_reset_beats", 64'(popped), 64'(2));
    ARESETn = 1'b0;
    #1;
    chk("midburst_reset_outputs",
        64'({ARREADY, RVALID, RLAST, MEM_REN, RRESP, RID, RDATA, MEM_RADDR}), 64'(0));
    exp_q.delete();
    hold_v = 1'b0;
    err_mode = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    run(mk(4'hB, 32'h20, 8'd1, 3'd2, 2'b01, 1'b0, 1'b0, 8, 9, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
